// File: rtl/fsim_pkg.sv
// Shared fault-simulation definitions: pattern-source FSM states, mode encodings
// and the primitive-polynomial tap masks used by the LFSR.
package fsim_pkg;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic MODE_EXH  = 1'b0;
  localparam logic MODE_LFSR = 1'b1;

  // Bit i set means stage i+1 feeds the XOR. Indexed by register width (2..16).
  localparam logic [15:0] LFSR_TAPS [0:16] = '{
    16'h0000, 16'h0000, 16'h0003, 16'h0006, 16'h000C, 16'h0014, 16'h0030,
    16'h0060, 16'h00B8, 16'h0110, 16'h0240, 16'h0500, 16'h0829, 16'h100D,
    16'h2015, 16'h6000, 16'hD008
  };

endpackage

// File: rtl/lfsr_next.sv
// One step of a maximal-length Fibonacci LFSR: shift left, XOR of taps into bit 0.
module lfsr_next
  import fsim_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic [WIDTH-1:0] cur,
  output logic [WIDTH-1:0] nxt
);

  localparam logic [15:0]      TAPS16 = LFSR_TAPS[WIDTH];
  localparam logic [WIDTH-1:0] TAPS   = TAPS16[WIDTH-1:0];

  assign nxt = {cur[WIDTH-2:0], ^(cur & TAPS)};

endmodule

// File: rtl/bist_pattern_gen.sv
// BIST test-pattern source: exhaustive count or LFSR stream onto the CUT inputs,
// with start/busy/done handshake and a hold input for downstream back-pressure.
module bist_pattern_gen
  import fsim_pkg::*;
#(
  parameter int               WIDTH        = 2,
  parameter int               NUM_PATTERNS = 4,
  parameter logic [WIDTH-1:0] SEED         = 'd1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             mode,
  input  logic             seed_load,
  input  logic [WIDTH-1:0] seed_in,
  input  logic             hold,
  output logic [WIDTH-1:0] pattern_out,
  output logic             pattern_valid,
  output logic [15:0]      pattern_idx,
  output logic             busy,
  output logic             done
);

  localparam logic [16:0] EXH_CNT   = 17'd1 << WIDTH;
  localparam logic [15:0] LAST_EXH  = 16'(EXH_CNT - 17'd1);
  localparam logic [15:0] LAST_LFSR = 16'(NUM_PATTERNS - 1);

  state_t           state, state_n;
  logic             mode_q, mode_n;
  logic [WIDTH-1:0] seed_q, seed_n;
  logic [WIDTH-1:0] pat_n, lfsr_nxt;
  logic             valid_n, busy_n, done_n;
  logic [15:0]      idx_n, last;

  lfsr_next #(.WIDTH(WIDTH)) u_lfsr (
    .cur (pattern_out),
    .nxt (lfsr_nxt)
  );

  assign last = (mode_q == MODE_LFSR) ? LAST_LFSR : LAST_EXH;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      mode_q        <= MODE_EXH;
      seed_q        <= SEED;
      pattern_out   <= '0;
      pattern_valid <= 1'b0;
      pattern_idx   <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
    end else begin
      state         <= state_n;
      mode_q        <= mode_n;
      seed_q        <= seed_n;
      pattern_out   <= pat_n;
      pattern_valid <= valid_n;
      pattern_idx   <= idx_n;
      busy          <= busy_n;
      done          <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    mode_n  = mode_q;
    seed_n  = seed_q;
    pat_n   = pattern_out;
    valid_n = pattern_valid;
    idx_n   = pattern_idx;
    busy_n  = busy;
    done_n  = done;
    case (state)
      IDLE: begin
        // A zero seed would lock the LFSR at all-zeros forever.
        if (seed_load)
          seed_n = (seed_in == '0) ? WIDTH'(1) : seed_in;
        if (start) begin
          state_n = RUN;
          mode_n  = mode;
          pat_n   = (mode == MODE_LFSR) ? seed_q : '0;
          idx_n   = '0;
          valid_n = 1'b1;
          busy_n  = 1'b1;
        end
      end
      RUN: begin
        if (!hold) begin
          if (pattern_idx == last) begin
            state_n = DONE;
            valid_n = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            idx_n = pattern_idx + 16'd1;
            pat_n = (mode_q == MODE_LFSR) ? lfsr_nxt : pattern_out + WIDTH'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
        done_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_bist_pattern_gen.sv
// Bench for bist_pattern_gen (WIDTH=2, NUM_PATTERNS=4): table of runs plus
// hand sequences for hold, mid-run reset and ignored start.
module tb_bist_pattern_gen;

  localparam int W  = 2;
  localparam int NP = 4;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         mode = 1'b0;
  logic         seed_load = 1'b0;
  logic [W-1:0] seed_in = '0;
  logic         hold = 1'b0;
  logic [W-1:0] pattern_out;
  logic         pattern_valid;
  logic [15:0]  pattern_idx;
  logic         busy;
  logic         done;

  bist_pattern_gen #(.WIDTH(W), .NUM_PATTERNS(NP), .SEED(2'd1)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .mode          (mode),
    .seed_load     (seed_load),
    .seed_in       (seed_in),
    .hold          (hold),
    .pattern_out   (pattern_out),
    .pattern_valid (pattern_valid),
    .pattern_idx   (pattern_idx),
    .busy          (busy),
    .done          (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] pat;
    logic [15:0]  idx;
  } exp_t;

  typedef struct packed {
    logic              ld_sep;
    logic              ld_same;
    logic [W-1:0]      seed;
    logic              mode;
    logic [3:0][W-1:0] exp;
  } vec_t;

  exp_t sb[$];
  exp_t mon_e;
  vec_t tbl [7];
  int   checks = 0;
  int   failures = 0;
  int   done_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic ls, input logic lm, input logic [W-1:0] sd,
                              input logic md, input logic [W-1:0] e0, input logic [W-1:0] e1,
                              input logic [W-1:0] e2, input logic [W-1:0] e3);
    vec_t v;
    v.ld_sep = ls; v.ld_same = lm; v.seed = sd; v.mode = md;
    v.exp = {e3, e2, e1, e0};
    return v;
  endfunction

  task automatic push_seq(input logic [3:0][W-1:0] e);
    exp_t x;
    for (int k = 0; k < NP; k++) begin
      x.pat = e[k];
      x.idx = 16'(k);
      sb.push_back(x);
    end
  endtask

  // Consumer side: a vector is taken on every valid, un-held cycle.
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (rst_n && pattern_valid && !hold) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pattern: got %0h idx %0d expected none", pattern_out, pattern_idx);
      end else begin
        mon_e = sb.pop_front();
        chk("pattern", 32'(pattern_out), 32'(mon_e.pat));
        chk("idx", 32'(pattern_idx), 32'(mon_e.idx));
        chk("busy_in_run", 32'(busy), 32'd1);
      end
    end
  end

  task automatic wait_done(input logic [W-1:0] last);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 50);
    if (!done) begin
      checks++;
      failures++;
      $display("FAIL done_timeout: got no done after %0d cycles expected done", n);
    end else begin
      chk("done_last_pattern", 32'(pattern_out), 32'(last));
      chk("done_valid_low", 32'(pattern_valid), 32'd0);
      chk("done_busy_low", 32'(busy), 32'd0);
    end
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("idle_busy_low", 32'(busy), 32'd0);
    chk("sb_drained", 32'(sb.size()), 32'd0);
  endtask

  task automatic run(input vec_t v);
    if (v.ld_sep) begin
      @(posedge clk); #1 seed_load = 1'b1; seed_in = v.seed;
      @(posedge clk); #1 seed_load = 1'b0;
    end
    @(posedge clk); #1 start = 1'b1; mode = v.mode;
    if (v.ld_same) begin seed_load = 1'b1; seed_in = v.seed; end
    push_seq(v.exp);
    @(posedge clk); #1 start = 1'b0; seed_load = 1'b0;
    wait_done(v.exp[3]);
  endtask

  initial begin
    int d0;
    int n;
    tbl[0] = mk(0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd2, 2'd3);  // exhaustive
    tbl[1] = mk(0, 0, 2'd0, 1, 2'd1, 2'd3, 2'd2, 2'd1);  // LFSR, reset seed
    tbl[2] = mk(1, 0, 2'd2, 1, 2'd2, 2'd1, 2'd3, 2'd2);  // loaded seed 10
    tbl[3] = mk(1, 0, 2'd0, 1, 2'd1, 2'd3, 2'd2, 2'd1);  // zero seed stored as 01
    tbl[4] = mk(0, 1, 2'd3, 1, 2'd1, 2'd3, 2'd2, 2'd1);  // load with start: old seed
    tbl[5] = mk(0, 0, 2'd0, 1, 2'd3, 2'd2, 2'd1, 2'd3);  // new seed 11 now active
    tbl[6] = mk(0, 0, 2'd0, 0, 2'd0, 2'd1, 2'd2, 2'd3);  // back to exhaustive

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pattern", 32'(pattern_out), 32'd0);
    chk("rst_valid", 32'(pattern_valid), 32'd0);
    chk("rst_idx", 32'(pattern_idx), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 7; i++) run(tbl[i]);

    // Hold for three edges at idx 1.
    push_seq({2'd3, 2'd2, 2'd1, 2'd0});
    @(posedge clk); #1 start = 1'b1; mode = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); #1 hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("hold_pattern", 32'(pattern_out), 32'd1);
      chk("hold_valid", 32'(pattern_valid), 32'd1);
      chk("hold_idx", 32'(pattern_idx), 32'd1);
      @(posedge clk); #1;
    end
    hold = 1'b0;
    wait_done(2'd3);

    // Reset in the middle of a run, at idx 2.
    push_seq({2'd3, 2'd2, 2'd1, 2'd0});
    @(posedge clk); #1 start = 1'b1; mode = 1'b0;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk);
    @(posedge clk); #1 rst_n = 1'b0;
    chk("pre_rst_idx", 32'(pattern_idx), 32'd2);
    @(posedge clk); #1 rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("midrst_pattern", 32'(pattern_out), 32'd0);
    chk("midrst_valid", 32'(pattern_valid), 32'd0);
    chk("midrst_idx", 32'(pattern_idx), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_done", 32'(done), 32'd0);
    run(tbl[0]);

    // start held during RUN and pulsed in DONE must not launch a second run.
    d0 = done_cnt;
    push_seq({2'd3, 2'd2, 2'd1, 2'd0});
    @(posedge clk); #1 start = 1'b1; mode = 1'b0;
    repeat (2) @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 50);
    chk("restart_done_seen", 32'(done), 32'd1);
    start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (8) @(negedge clk);
    chk("restart_one_done", 32'(done_cnt - d0), 32'd1);
    chk("restart_sb_drained", 32'(sb.size()), 32'd0);
    chk("restart_busy_low", 32'(busy), 32'd0);
    chk("restart_valid_low", 32'(pattern_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
